// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshake, shifts and an iterative unsigned multiply.
// Define ALU_SAT_EN to enable saturating signed add (1100) and subtract (1101).
//
// state  | meaning
// S_IDLE | ready for a new operation (subject to output register space)
// S_MUL  | shift-and-add multiply in progress, one multiplier bit per cycle
module alu_pipe #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             neg,
    output logic             ovf,
    output logic             carry,
    output logic             err
);
    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH:0]   ONE_X   = {{WIDTH{1'b0}}, 1'b1};
    localparam logic [SHW-1:0]   CNT_ONE = {{(SHW-1){1'b0}}, 1'b1};
    localparam logic [SHW-1:0]   CNT_TOP = {SHW{1'b1}};
    localparam logic [3:0]       OP_MUL  = 4'b1011;

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t             state;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   mplier;
    logic [SHW-1:0]     cnt;
    logic [SHW-1:0]     sh;
    logic [WIDTH:0]     sum_ab;
    logic [WIDTH:0]     diff_ab;
    logic [WIDTH:0]     inc_a;
    logic [WIDTH:0]     dec_a;
    logic               add_ovf;
    logic               sub_ovf;
    logic               accept;
    logic [WIDTH-1:0]   c_res;
    logic               c_ovf;
    logic               c_carry;
    logic               c_err;

    assign in_ready = (state == S_IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    assign sh      = b[SHW-1:0];
    assign sum_ab  = {1'b0, a} + {1'b0, b};
    assign diff_ab = {1'b0, a} - {1'b0, b};
    assign inc_a   = {1'b0, a} + ONE_X;
    assign dec_a   = {1'b0, a} - ONE_X;
    assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum_ab[WIDTH-1] != a[WIDTH-1]);
    assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff_ab[WIDTH-1] != a[WIDTH-1]);

    assign acc_next = acc + (mplier[0] ? mcand : '0);

    always_comb begin
        c_res   = '0;
        c_ovf   = 1'b0;
        c_carry = 1'b0;
        c_err   = 1'b0;
        case (op)
            4'b0000: c_res = ~a;
            4'b0001: c_res = a & b;
            4'b0010: c_res = a ^ b;
            4'b0011: c_res = a | b;
            4'b0100: begin
                c_res   = dec_a[WIDTH-1:0];
                c_ovf   = (a == MIN_NEG);
                c_carry = |a;
            end
            4'b0101: begin
                c_res   = sum_ab[WIDTH-1:0];
                c_ovf   = add_ovf;
                c_carry = sum_ab[WIDTH];
            end
            4'b0110: begin
                c_res   = diff_ab[WIDTH-1:0];
                c_ovf   = sub_ovf;
                c_carry = ~diff_ab[WIDTH];
            end
            4'b0111: begin
                c_res   = inc_a[WIDTH-1:0];
                c_ovf   = (a == MAX_POS);
                c_carry = inc_a[WIDTH];
            end
            4'b1000: c_res = a << sh;
            4'b1001: c_res = a >> sh;
            4'b1010: c_res = $signed(a) >>> sh;
            4'b1011: c_res = '0;
`ifdef ALU_SAT_EN
            // Clamp direction follows the sign of A: overflow only happens away from it.
            4'b1100: begin
                c_res = add_ovf ? (a[WIDTH-1] ? MIN_NEG : MAX_POS) : sum_ab[WIDTH-1:0];
                c_ovf = add_ovf;
            end
            4'b1101: begin
                c_res = sub_ovf ? (a[WIDTH-1] ? MIN_NEG : MAX_POS) : diff_ab[WIDTH-1:0];
                c_ovf = sub_ovf;
            end
`endif
            default: c_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            neg       <= 1'b0;
            ovf       <= 1'b0;
            carry     <= 1'b0;
            err       <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (op == OP_MUL) begin
                            state  <= S_MUL;
                            acc    <= '0;
                            mcand  <= {{WIDTH{1'b0}}, a};
                            mplier <= b;
                            cnt    <= CNT_TOP;
                        end else begin
                            out_valid <= 1'b1;
                            result    <= c_res;
                            zero      <= (c_res == '0);
                            neg       <= c_res[WIDTH-1];
                            ovf       <= c_ovf;
                            carry     <= c_carry;
                            err       <= c_err;
                        end
                    end
                end
                S_MUL: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - CNT_ONE;
                    // Final step folds the last partial product straight into the result.
                    if (cnt == '0) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b1;
                        result    <= acc_next[WIDTH-1:0];
                        zero      <= (acc_next[WIDTH-1:0] == '0);
                        neg       <= acc_next[WIDTH-1];
                        ovf       <= |acc_next[2*WIDTH-1:WIDTH];
                        carry     <= 1'b0;
                        err       <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe at WIDTH=8: directed vectors, a behavioural
// arithmetic model and a per-cycle output checker with latency tracking.
module tb_alu_pipe;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic [3:0]   op = 4'h0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] result;
    logic         zero, neg, ovf, carry, err;

    alu_pipe #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .neg(neg), .ovf(ovf), .carry(carry), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [12:0] exp;
        bit          has_lit;
        logic [12:0] lit;
        int          acc;
        bit          is_mul;
        bit          seen;
    } ent_t;

    ent_t q[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    endtask

    // {err, carry, ovf, neg, zero, result}
    function automatic logic [12:0] pk(input int r, input bit z, input bit n, input bit v,
                                       input bit c, input bit e);
        logic [7:0] r8;
        r8 = 8'(r);
        return {e, c, v, n, z, r8};
    endfunction

    function automatic logic [12:0] model(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y);
        int ua, ub, sa, sb, sh, r, s;
        bit v, c, e;
        ua = x; ub = y; sa = $signed(x); sb = $signed(y); sh = ub % 8;
        r = 0; s = 0; v = 0; c = 0; e = 0;
        case (o)
            4'd0: r = 255 - ua;
            4'd1: r = ua & ub;
            4'd2: r = ua ^ ub;
            4'd3: r = ua | ub;
            4'd4: begin r = ua - 1;  v = (sa - 1 < -128); c = (ua >= 1); end
            4'd5: begin r = ua + ub; v = (sa + sb > 127) || (sa + sb < -128); c = (ua + ub > 255); end
            4'd6: begin r = ua - ub; v = (sa - sb > 127) || (sa - sb < -128); c = (ua >= ub); end
            4'd7: begin r = ua + 1;  v = (sa + 1 > 127); c = (ua + 1 > 255); end
            4'd8: r = ua * (1 << sh);
            4'd9: r = ua / (1 << sh);
            4'd10: r = sa >>> sh;
            4'd11: begin r = ua * ub; v = (r > 255); end
`ifdef ALU_SAT_EN
            4'd12, 4'd13: begin
                s = (o == 4'd12) ? sa + sb : sa - sb;
                if (s > 127) begin r = 127; v = 1; end
                else if (s < -128) begin r = -128; v = 1; end
                else r = s;
            end
`endif
            default: begin r = 0; e = 1; end
        endcase
        r = r & 255;
        return pk(r, r == 0, r >= 128, v, c, e);
    endfunction

    // Output checker: runs 1 time unit after each falling edge, after the driver's updates.
    always @(negedge clk) begin
        ent_t e0;
        #1;
        if (rst_n) begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_out_valid", {19'd0, err, carry, ovf, neg, zero, result}, 32'h0);
                end else begin
                    e0 = q[0];
                    chk("out_vs_model", {err, carry, ovf, neg, zero, result}, e0.exp);
                    if (e0.has_lit) chk("out_vs_literal", {err, carry, ovf, neg, zero, result}, e0.lit);
                    if (!e0.seen) begin
                        chk(e0.is_mul ? "mul_latency" : "op_latency", cyc - e0.acc, e0.is_mul ? 9 : 1);
                        e0.seen = 1;
                        q[0] = e0;
                    end
                    if (!out_ready) chk("stall_in_ready", in_ready, 0);
                    else void'(q.pop_front());
                end
            end else if (q.size() > 0) begin
                if (q[q.size()-1].is_mul) chk("mul_busy_in_ready", in_ready, 0);
                if (cyc - q[0].acc > (q[0].is_mul ? 9 : 1)) begin
                    chk("result_late", out_valid, 1);
                    void'(q.pop_front());
                end
            end
        end
    end

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic do_op(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                         input bit has_lit, input logic [12:0] l, output int tries);
        ent_t e;
        op = o; a = x; b = y; in_valid = 1'b1;
        tries = 0;
        #2;
        while (!in_ready && tries < 30) begin
            @(negedge clk); #2;
            tries++;
        end
        if (!in_ready) begin
            chk("accept_timeout", in_ready, 1);
        end else begin
            e.exp = model(o, x, y); e.has_lit = has_lit; e.lit = l;
            e.acc = cyc; e.is_mul = (o == 4'b1011); e.seen = 0;
            q.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic run(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y, input logic [12:0] l);
        int t;
        do_op(o, x, y, 1'b1, l, t);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_flags", {zero, neg, ovf, carry, err}, 0);
        chk("rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run(4'b0101, 8'h7F, 8'h01, pk(8'h80, 0, 1, 1, 0, 0));
        run(4'b0110, 8'h05, 8'h05, pk(8'h00, 1, 0, 0, 1, 0));
        run(4'b0111, 8'h7F, 8'h00, pk(8'h80, 0, 1, 1, 0, 0));
        run(4'b0100, 8'h80, 8'h00, pk(8'h7F, 0, 0, 1, 1, 0));
        run(4'b0111, 8'hFF, 8'h00, pk(8'h00, 1, 0, 0, 1, 0));
        run(4'b0100, 8'h00, 8'h00, pk(8'hFF, 0, 1, 0, 0, 0));
        run(4'b0101, 8'h80, 8'h80, pk(8'h00, 1, 0, 1, 1, 0));
        run(4'b0110, 8'h80, 8'h01, pk(8'h7F, 0, 0, 1, 1, 0));
        run(4'b0110, 8'h03, 8'h05, pk(8'hFE, 0, 1, 0, 0, 0));
        run(4'b0000, 8'h0F, 8'h00, pk(8'hF0, 0, 1, 0, 0, 0));
        run(4'b0001, 8'h3C, 8'hF0, pk(8'h30, 0, 0, 0, 0, 0));
        run(4'b0010, 8'h3C, 8'hF0, pk(8'hCC, 0, 1, 0, 0, 0));
        run(4'b0011, 8'h3C, 8'h03, pk(8'h3F, 0, 0, 0, 0, 0));
        run(4'b1010, 8'h90, 8'h02, pk(8'hE4, 0, 1, 0, 0, 0));
        run(4'b1000, 8'h81, 8'h09, pk(8'h02, 0, 0, 0, 0, 0));
        run(4'b1001, 8'h90, 8'h03, pk(8'h12, 0, 0, 0, 0, 0));
        run(4'b1011, 8'h10, 8'h10, pk(8'h00, 1, 0, 1, 0, 0));
        run(4'b1011, 8'h0D, 8'h0B, pk(8'h8F, 0, 1, 0, 0, 0));
        run(4'b0101, 8'h11, 8'h22, pk(8'h33, 0, 0, 0, 0, 0));
        run(4'b1111, 8'h12, 8'h34, pk(8'h00, 1, 0, 0, 0, 1));
        run(4'b1110, 8'h12, 8'h34, pk(8'h00, 1, 0, 0, 0, 1));
`ifdef ALU_SAT_EN
        run(4'b1100, 8'h70, 8'h20, pk(8'h7F, 0, 0, 1, 0, 0));
        run(4'b1101, 8'h80, 8'h01, pk(8'h80, 0, 1, 1, 0, 0));
        run(4'b1100, 8'h10, 8'h20, pk(8'h30, 0, 0, 0, 0, 0));
`else
        run(4'b1100, 8'h70, 8'h20, pk(8'h00, 1, 0, 0, 0, 1));
        run(4'b1101, 8'h80, 8'h01, pk(8'h00, 1, 0, 0, 0, 1));
`endif

        // Back-pressure: hold one result, then drain and accept in the same cycle.
        repeat (3) @(negedge clk);
        out_ready = 1'b0;
        run(4'b0001, 8'hA5, 8'h0F, pk(8'h05, 0, 0, 0, 0, 0));
        repeat (4) @(negedge clk);
        #1;
        chk("stall_result_held", result, 8'h05);
        chk("stall_out_valid", out_valid, 1);
        @(negedge clk);
        out_ready = 1'b1;
        do_op(4'b0010, 8'hA5, 8'h0F, 1'b1, pk(8'hAA, 0, 1, 0, 0, 0), t);
        chk("drain_and_accept_same_cycle", t, 0);
        repeat (3) @(negedge clk);

        // Reset in the middle of a multiply.
        do_op(4'b1011, 8'h0F, 8'h11, 1'b0, 13'h0, t);
        @(negedge clk);
        rst_n = 1'b0;
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midmul_rst_out_valid", out_valid, 0);
        chk("midmul_rst_in_ready", in_ready, 1);
        chk("midmul_rst_result", result, 0);
        repeat (12) @(negedge clk);
        run(4'b0101, 8'h01, 8'h02, pk(8'h03, 0, 0, 0, 0, 0));
        run(4'b1011, 8'hFF, 8'hFF, pk(8'h01, 0, 0, 1, 0, 0));
        repeat (14) @(negedge clk);
        chk("queue_drained", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
